// File: rtl/core_seq_pkg.sv
// core_sequencer shared types and constants.
// State encoding, error codes, class bundle, timeout defaults.
package core_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_RETIRE = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_ALU  = 2'b01;
   localparam logic [1:0] ERR_MEM  = 2'b10;
   localparam logic [1:0] ERR_LDST = 2'b11;

   localparam int DEF_ALU_TIMEOUT = 64;
   localparam int DEF_MEM_TIMEOUT = 16;
   localparam int DEF_CNT_W       = 16;

   typedef struct packed {
      logic ld;
      logic st;
      logic wb;
      logic cmp;
      logic multi;
   } cls_t;

   function automatic int tmr_width(input int a, input int b);
      return $clog2(((a > b) ? a : b) + 1);
   endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer control bus.
// Class/handshake inputs in, datapath enables and status out.
interface core_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             run;
   logic             is_ld;
   logic             is_st;
   logic             is_wb;
   logic             is_cmp;
   logic             is_multi;
   logic             branch_taken;
   logic             alu_done;
   logic             mem_ready;
   logic             ir_en;
   logic             alu_start;
   logic             flags_wr;
   logic             mem_rd;
   logic             mem_wr;
   logic             rf_wr;
   logic             pc_en;
   logic             pc_sel_branch;
   logic [2:0]       state;
   logic             busy;
   logic             error;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output run, is_ld, is_st, is_wb, is_cmp, is_multi,
      output branch_taken, alu_done, mem_ready,
      input  ir_en, alu_start, flags_wr, mem_rd, mem_wr,
      input  rf_wr, pc_en, pc_sel_branch,
      input  state, busy, error, err_code, instr_count
   );

   modport slave (
      input  run, is_ld, is_st, is_wb, is_cmp, is_multi,
      input  branch_taken, alu_done, mem_ready,
      output ir_en, alu_start, flags_wr, mem_rd, mem_wr,
      output rf_wr, pc_en, pc_sel_branch,
      output state, busy, error, err_code, instr_count
   );
endinterface

// File: rtl/wait_timer.sv
// Shared wait-cycle counter for EXEC and MEM.
// expired is high during the limit-th cycle since load.
module wait_timer #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic         expired
);
   logic [W-1:0] cnt;

   // count waiting cycles; saturate so it never wraps under the limit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (load)
         cnt <= '0;
      else if (enable && cnt != '1)
         cnt <= cnt + 1'b1;
   end

   assign expired = (cnt >= limit - 1'b1);
endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer.
// FETCH/DECODE/EXEC/MEM/WB/RETIRE with timeouts and sticky error.
module core_sequencer
   import core_seq_pkg::*;
#(
   parameter int ALU_TIMEOUT = DEF_ALU_TIMEOUT,
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int CNT_W       = DEF_CNT_W
) (
   input logic              clk,
   input logic              reset,
   core_sequencer_if.slave  bus
);
   localparam int TW = tmr_width(ALU_TIMEOUT, MEM_TIMEOUT);

   state_t           cur;
   state_t           nxt;
   cls_t             cls;
   cls_t             cls_n;
   logic [1:0]       code;
   logic [1:0]       code_n;
   logic             tmr_ld;
   logic             tmr_en;
   logic             expired;
   logic [TW-1:0]    limit;
   logic             ir_en_q;
   logic             alu_start_q;
   logic             flags_wr_q;
   logic             mem_rd_q;
   logic             mem_wr_q;
   logic             rf_wr_q;
   logic             pc_en_q;
   logic             sel_q;
   logic             busy_q;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;

   wait_timer #(.W(TW)) u_tmr (
      .clk     (clk),
      .reset   (reset),
      .load    (tmr_ld),
      .enable  (tmr_en),
      .limit   (limit),
      .expired (expired)
   );

   // next state, class capture and timer control
   always_comb begin
      cls_n  = cls;
      nxt    = cur;
      code_n = code;
      if (cur == S_DECODE) begin
         cls_n.ld    = bus.is_ld;
         cls_n.st    = bus.is_st;
         cls_n.wb    = bus.is_wb;
         cls_n.cmp   = bus.is_cmp;
         cls_n.multi = bus.is_multi;
      end
      case (cur)
         S_IDLE:
            if (bus.run) nxt = S_FETCH;
         S_FETCH:
            nxt = S_DECODE;
         S_DECODE:
            if (cls_n.ld && cls_n.st) begin
               nxt    = S_ERR;
               code_n = ERR_LDST;
            end else begin
               nxt = S_EXEC;
            end
         S_EXEC:
            if (!cls.multi || bus.alu_done) begin
               if (cls.ld || cls.st) nxt = S_MEM;
               else if (cls.wb)      nxt = S_WB;
               else                  nxt = S_RETIRE;
            end else if (expired) begin
               nxt    = S_ERR;
               code_n = ERR_ALU;
            end
         S_MEM:
            if (bus.mem_ready) begin
               nxt = cls.ld ? S_WB : S_RETIRE;
            end else if (expired) begin
               nxt    = S_ERR;
               code_n = ERR_MEM;
            end
         S_WB:
            nxt = S_RETIRE;
         S_RETIRE:
            nxt = bus.run ? S_FETCH : S_IDLE;
         S_ERR:
            nxt = S_ERR;
         default:
            nxt = S_ERR;
      endcase
      limit  = (cur == S_MEM) ? TW'(MEM_TIMEOUT)
                              : TW'(ALU_TIMEOUT);
      tmr_ld = (nxt != cur);
      tmr_en = (cur == S_EXEC) || (cur == S_MEM);
   end

   // state, latches and registered enables decoded from next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur         <= S_IDLE;
         cls         <= '0;
         code        <= ERR_NONE;
         ir_en_q     <= 1'b0;
         alu_start_q <= 1'b0;
         flags_wr_q  <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         rf_wr_q     <= 1'b0;
         pc_en_q     <= 1'b0;
         sel_q       <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         cur         <= nxt;
         cls         <= cls_n;
         code        <= code_n;
         ir_en_q     <= (nxt == S_FETCH);
         alu_start_q <= (nxt == S_EXEC) && (cur == S_DECODE)
                        && cls_n.multi;
         flags_wr_q  <= (nxt == S_EXEC) && cls_n.cmp;
         mem_rd_q    <= (nxt == S_MEM) && cls_n.ld;
         mem_wr_q    <= (nxt == S_MEM) && cls_n.st;
         rf_wr_q     <= (nxt == S_WB);
         pc_en_q     <= (nxt == S_RETIRE);
         busy_q      <= !((nxt == S_IDLE) || (nxt == S_ERR));
         err_q       <= (nxt == S_ERR);
         if (cur == S_EXEC && nxt != S_EXEC && nxt != S_ERR)
            sel_q <= bus.branch_taken;
         if (cur == S_RETIRE)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.ir_en         = ir_en_q;
   assign bus.alu_start     = alu_start_q;
   assign bus.flags_wr      = flags_wr_q;
   assign bus.mem_rd        = mem_rd_q;
   assign bus.mem_wr        = mem_wr_q;
   assign bus.rf_wr         = rf_wr_q;
   assign bus.pc_en         = pc_en_q;
   assign bus.pc_sel_branch = sel_q;
   assign bus.state         = cur;
   assign bus.busy          = busy_q;
   assign bus.error         = err_q;
   assign bus.err_code      = code;
   assign bus.instr_count   = cnt_q;
endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameters SHALL be: ALU_TIMEOUT, default 64, max cycles waiting on alu_done; MEM_TIMEOUT, default 16, max cycles waiting on mem_ready; CNT_W, default 16, width of instr_count.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 run  in  1  level; high permits fetching new instructions.
REQ-005 is_ld, is_st, is_wb, is_cmp, is_multi  in  1 each  instruction class from control unit; is_multi = mul/div/mod.
REQ-006 branch_taken  in  1  from branch unit.
REQ-007 alu_done  in  1  multi-cycle ALU completion pulse.
REQ-008 mem_ready  in  1  data memory access complete.
REQ-009 ir_en, alu_start, flags_wr, mem_rd, mem_wr, rf_wr, pc_en, pc_sel_branch  out  1 each  datapath enables.
REQ-010 state  out  3  current FSM state; busy  out  1  state not IDLE/ERR.
REQ-011 error  out  1  sticky fault; err_code  out  2  01 ALU timeout, 10 MEM timeout, 11 illegal ld+st.
REQ-012 instr_count  out  CNT_W  retired-instruction count.

Function
REQ-013 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, RETIRE, ERR.
REQ-014 IDLE -> FETCH when run=1; else remain.
REQ-015 FETCH: ir_en=1 for exactly one cycle -> DECODE.
REQ-016 DECODE: one cycle; class inputs latched at end of DECODE and ignored until next DECODE; is_ld & is_st both 1 -> ERR, err_code 11.
REQ-017 EXEC, is_multi=0: one cycle. is_multi=1: alu_start=1 in first EXEC cycle only; stay until alu_done sampled high.
REQ-018 Last EXEC cycle: flags_wr=1 if latched is_cmp; branch_taken latched into pc_sel_branch register.
REQ-019 After EXEC: ld or st -> MEM; else is_wb -> WB; else -> RETIRE.
REQ-020 MEM: mem_rd (ld) or mem_wr (st) held high until mem_ready sampled high; then ld -> WB, st -> RETIRE.
REQ-021 WB: rf_wr=1 one cycle -> RETIRE.
REQ-022 RETIRE: pc_en=1 one cycle, pc_sel_branch driven from latch; instr_count +1, wrapping to 0 at 2^CNT_W; -> FETCH if run=1 else IDLE.
REQ-023 Outputs SHALL be decoded only from state and latched registers; no combinational input-to-output path.
REQ-024 Timeout counter cleared on entry to EXEC and MEM; EXEC (is_multi) or MEM occupying limit cycles without completion -> ERR with matching err_code.
REQ-025 Completion sampled on the same cycle the limit is reached SHALL win over timeout.
REQ-026 run deasserted mid-instruction SHALL not abort it; instruction retires, then IDLE.
REQ-027 ERR: all enables 0, error=1, exits only by reset.
REQ-028 Latency: plain ALU op 4 cycles; with WB 5; load with immediate mem_ready 6; store 5.

Reset
REQ-029 reset low SHALL immediately force IDLE, all enables 0, pc_sel_branch 0, busy 0, error 0, err_code 00, instr_count 0, latched classes 0, timeout counter 0.
REQ-030 Reset asserted mid-instruction SHALL abandon it without retiring; first FETCH occurs the first cycle after release with run=1.

Structure
REQ-031 Package core_seq_pkg SHALL hold state encoding, err_code constants and default timeout values.
REQ-032 One sub-module wait_timer (load, enable, limit, expired) SHALL implement the shared timeout counter.

Verification
REQ-033 run=1, plain add, is_wb=1 -> ir_en, EXEC, rf_wr, pc_en in cycles 1,3,4,5; instr_count=1.
REQ-034 mul, alu_done on 5th EXEC cycle -> alu_start one pulse, EXEC 5 cycles, no error.
REQ-035 load, mem_ready never asserted, MEM_TIMEOUT=16 -> ERR after 16 MEM cycles, err_code 10, mem_rd drops.
REQ-036 cmp then branch_taken=1 -> flags_wr once for cmp; branch retires with pc_en=1, pc_sel_branch=1.
REQ-037 CNT_W=4, 16 retires -> instr_count wraps 15 -> 0; reset during MEM -> IDLE, mem_rd 0 same cycle, count 0.
